shift_add_multiplier: RTL and testbench

//  Unsigned sequential shift-add multiplier; the multiply counterpart of the restoring divider.

---
 rtl/mul_pkg.sv | 11 +
 rtl/shift_add_multiplier_if.sv | 15 +
 rtl/mul_iter_cnt.sv | 38 +++
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_shift_add_multiplier.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b1000,
    ST_START = 4'b0100,
    ST_LOAD  = 4'b0010,
    ST_CALC  = 4'b0001
  } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start handshake and operand/product bus of the shift-add multiplier.
interface shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 8
);

  logic                   st;
  logic [WIDTH-1:0]       a_in;
  logic [WIDTH-1:0]       b_in;
  logic                   ready;
  logic [2*WIDTH-1:0]     product;

  modport master (output st, a_in, b_in, input ready, product);
  modport slave  (input st, a_in, b_in, output ready, product);

endinterface

// File: rtl/mul_iter_cnt.sv
// Iteration counter for the multiplier; co flags the last add-and-shift step.
module mul_iter_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             cen,
  output logic [CNT_W-1:0] q,
  output logic             co
);

  logic [CNT_W-1:0] q_d;
  logic [CNT_W-1:0] q_q;

  // init wins over cen so a fresh operation never inherits a stale count
  always_comb begin
    q_d = q_q;
    if (init) begin
      q_d = '0;
    end else if (cen) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = (q_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-add multiplier: one add-and-shift step per clock,
// product {ACC,Q} valid and held while ready is high.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_t        state_d;
  mul_state_t        state_q;
  logic              ready_d;
  logic              ready_q;
  logic [WIDTH-1:0]  m_d;
  logic [WIDTH-1:0]  m_q;
  logic [WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  q_d;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH:0]    sum_c;

  logic              ld_m;
  logic              ld_q;
  logic              init_acc;
  logic              step;
  logic              init_c;
  logic              cen;
  logic              co;
  logic [CNT_W-1:0]  cnt_unused;

  mul_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .init (init_c),
    .cen  (cen),
    .q    (cnt_unused),
    .co   (co)
  );

  // Controller: start acts on the falling edge of st, then WIDTH CALC steps
  always_comb begin
    state_d  = state_q;
    ld_m     = 1'b0;
    ld_q     = 1'b0;
    init_acc = 1'b0;
    step     = 1'b0;
    init_c   = 1'b0;
    cen      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.st) state_d = ST_START;
      end
      ST_START: begin
        if (!bus.st) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_m     = 1'b1;
        ld_q     = 1'b1;
        init_acc = 1'b1;
        init_c   = 1'b1;
        state_d  = ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        cen  = 1'b1;
        if (co) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: the add carry becomes the new ACC MSB after the right shift
  always_comb begin
    sum_c = (WIDTH+1)'(acc_q) + (q_q[0] ? (WIDTH+1)'(m_q) : (WIDTH+1)'(0));
    m_d   = m_q;
    acc_d = acc_q;
    q_d   = q_q;
    if (ld_m)     m_d   = bus.a_in;
    if (init_acc) acc_d = '0;
    if (ld_q)     q_d   = bus.b_in;
    if (step) begin
      acc_d = sum_c[WIDTH:1];
      q_d   = {sum_c[0], q_q[WIDTH-1:1]};
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.product = {acc_q, q_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed tables, multi-cycle corner cases and
// random operands at WIDTH=8 and WIDTH=4, checked against plain a*b.
module tb_shift_add_multiplier;

  logic clk;
  logic rst;

  shift_add_multiplier_if #(.WIDTH(8)) bus8 ();
  shift_add_multiplier_if #(.WIDTH(4)) bus4 ();

  shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec4_t;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Counts negedges while ready is low; operand inputs are scribbled once in CALC.
  task automatic wait_ready8(output int lat);
    lat = 0;
    while (bus8.ready !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
      if (lat >= 3 && bus8.ready !== 1'b1) begin
        bus8.a_in = 8'($urandom);
        bus8.b_in = 8'($urandom);
      end
    end
  endtask

  task automatic wait_ready4(output int lat);
    lat = 0;
    while (bus4.ready !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with ready high; starts immediately (no idle gap).
  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    bus8.a_in = a;
    bus8.b_in = b;
    bus8.st   = 1'b1;
    @(negedge clk);
    bus8.st = 1'b0;
    wait_ready8(lat);
    p = bus8.product;
  endtask

  task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat);
    bus4.a_in = a;
    bus4.b_in = b;
    bus4.st   = 1'b1;
    @(negedge clk);
    bus4.st = 1'b0;
    wait_ready4(lat);
    p = bus4.product;
  endtask

  initial begin
    vec8_t       tbl8 [7];
    vec4_t       tbl4 [4];
    logic [15:0] p8;
    logic [7:0]  p4;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [3:0]  sa;
    logic [3:0]  sb;
    int          lat;
    int          bad;

    tbl8[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
    tbl8[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    tbl8[2] = '{a: 8'd0,   b: 8'd173, p: 16'd0};
    tbl8[3] = '{a: 8'd1,   b: 8'd173, p: 16'd173};
    tbl8[4] = '{a: 8'd173, b: 8'd1,   p: 16'd173};
    tbl8[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    tbl8[6] = '{a: 8'd200, b: 8'd200, p: 16'd40000};
    tbl4[0] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    tbl4[1] = '{a: 4'd9,  b: 4'd7,  p: 8'd63};
    tbl4[2] = '{a: 4'd0,  b: 4'd15, p: 8'd0};
    tbl4[3] = '{a: 4'd15, b: 4'd1,  p: 8'd15};

    rst = 1'b1;
    bus8.st = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus4.st = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_ready8",   64'(bus8.ready),   64'd1);
    chk("reset_product8", 64'(bus8.product), 64'd0);
    chk("reset_ready4",   64'(bus4.ready),   64'd1);
    chk("reset_product4", 64'(bus4.product), 64'd0);

    // Reset in the middle of CALC for 200*200
    bus8.a_in = 8'd200; bus8.b_in = 8'd200; bus8.st = 1'b1;
    @(negedge clk);
    bus8.st = 1'b0;
    repeat (5) @(negedge clk);
    chk("midcalc_busy", 64'(bus8.ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready",   64'(bus8.ready),   64'd1);
    chk("abort_product", 64'(bus8.product), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    mul8(8'd200, 8'd200, p8, lat);
    chk("rerun_200x200", 64'(p8), 64'd40000);

    // Directed WIDTH=8 table; latency is WIDTH+2 negedges of ready low
    for (int i = 0; i < 7; i++) begin
      mul8(tbl8[i].a, tbl8[i].b, p8, lat);
      chk($sformatf("tbl8_%0dx%0d", tbl8[i].a, tbl8[i].b), 64'(p8), 64'(tbl8[i].p));
      chk("tbl8_latency", 64'(lat), 64'd10);
    end

    // st held high 5 cycles; operands changed while in START are the ones used
    bus8.a_in = 8'd1; bus8.b_in = 8'd1; bus8.st = 1'b1;
    repeat (5) @(negedge clk);
    chk("st_high_start", 64'(bus8.ready), 64'd0);
    bus8.a_in = 8'd37; bus8.b_in = 8'd91;
    @(negedge clk);
    chk("st_high_still_start", 64'(bus8.ready), 64'd0);
    bus8.st = 1'b0;
    wait_ready8(lat);
    chk("st_fall_latency", 64'(lat), 64'd10);
    chk("st_fall_product", 64'(bus8.product), 64'd3367);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus8.a_in = 8'($urandom);
      bus8.b_in = 8'($urandom);
      @(negedge clk);
      if (bus8.product !== 16'd3367 || bus8.ready !== 1'b1) bad++;
    end
    chk("idle_hold_20", 64'(bad), 64'd0);

    // st raised during CALC is ignored, then restarts as soon as IDLE is reached
    bus8.a_in = 8'd100; bus8.b_in = 8'd3; bus8.st = 1'b1;
    @(negedge clk);
    bus8.st = 1'b0;
    repeat (4) @(negedge clk);
    bus8.st = 1'b1;
    bus8.a_in = 8'd7; bus8.b_in = 8'd9;
    lat = 0;
    while (bus8.ready !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    chk("st_in_calc_product", 64'(bus8.product), 64'd300);
    @(negedge clk);
    chk("restart_immediate", 64'(bus8.ready), 64'd0);
    bus8.st = 1'b0;
    wait_ready8(lat);
    chk("restart_product", 64'(bus8.product), 64'd63);

    // Random WIDTH=8
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      mul8(ra, rb, p8, lat);
      chk($sformatf("rand8_%0dx%0d", ra, rb), 64'(p8), 64'(ra) * 64'(rb));
    end

    // WIDTH=4: table then random, all back-to-back
    for (int i = 0; i < 4; i++) begin
      mul4(tbl4[i].a, tbl4[i].b, p4, lat);
      chk($sformatf("tbl4_%0dx%0d", tbl4[i].a, tbl4[i].b), 64'(p4), 64'(tbl4[i].p));
      chk("tbl4_latency", 64'(lat), 64'd6);
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 4'($urandom);
      sb = 4'($urandom);
      mul4(sa, sb, p4, lat);
      chk($sformatf("rand4_%0dx%0d", sa, sb), 64'(p4), 64'(sa) * 64'(sb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
